serial_add_ctrl: RTL and testbench

//   Bit-serial adder around a single 1-bit full-adder cell. Accepts two WIDTH-bit

---
 rtl/serial_add_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts operands over valid/ready, adds LSB-first
// one bit per clock through a single full-adder cell, returns sum/cout over valid/ready.
// Optional signed-overflow output is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              c_q, c_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              bit_s, bit_co;
`ifdef SERIAL_ADD_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // The single full-adder cell
    assign bit_s  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign bit_co = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        c_d       = c_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                sum_sh_d = {bit_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                c_d      = bit_co;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    // Result registers only update here so they hold outside DONE
                    sum_d   = {bit_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = bit_co;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = c_q ^ bit_co;
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            c_q      <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            c_q      <= c_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); checks ovf too when
// SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full transaction with latency and handshake checks; starts and ends at a negedge.
    task automatic add_txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tcin, input logic [W-1:0] es, input logic ec,
                           input logic eo);
        check({tag, ".in_ready"}, 16'(in_ready), 16'd1);
        a = ta; b = tb; cin = tcin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".busy"}, 16'(in_ready), 16'd0);
        repeat (W - 1) @(negedge clk);
        check({tag, ".early"}, 16'(out_valid), 16'd0);
        @(negedge clk);
        check({tag, ".out_valid"}, 16'(out_valid), 16'd1);
        check({tag, ".sum"}, 16'(sum), 16'(es));
        check({tag, ".cout"}, 16'(cout), 16'(ec));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, ".ovf"}, 16'(ovf), 16'(eo));
`else
        if (eo === 1'bx) $display("unexpected x in ovf vector");
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".drop"}, 16'(out_valid), 16'd0);
        check({tag, ".idle"}, 16'(in_ready), 16'd1);
        check({tag, ".hold"}, 16'(sum), 16'(es));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   gold;
        logic         gold_ovf;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.in_ready", 16'(in_ready), 16'd1);
        check("rst.out_valid", 16'(out_valid), 16'd0);
        check("rst.sum", 16'(sum), 16'd0);
        check("rst.cout", 16'(cout), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        add_txn("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        add_txn("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        add_txn("max",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Backpressure: 0x3C + 0x5A + 1 = 0x97, held for 5 cycles; stray in_valid ignored
        a = 8'h3C; b = 8'h5A; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (W) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            a = 8'h11; b = 8'h22; cin = 1'b0;
            check("bp.out_valid", 16'(out_valid), 16'd1);
            check("bp.sum", 16'(sum), 16'h97);
            check("bp.cout", 16'(cout), 16'd0);
            check("bp.in_ready", 16'(in_ready), 16'd0);
`ifdef SERIAL_ADD_OVF_EN
            check("bp.ovf", 16'(ovf), 16'd1);
`endif
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp.still", 16'(out_valid), 16'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.drop", 16'(out_valid), 16'd0);
        @(negedge clk);
        check("bp.no_accept", 16'(in_ready), 16'd1);

        // Reset in the middle of 0xAA + 0x55
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 16'(out_valid), 16'd0);
        check("arst.in_ready", 16'(in_ready), 16'd1);
        check("arst.sum", 16'(sum), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add_txn("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
        add_txn("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        add_txn("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        add_txn("ovf_none", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
`endif

        // Back-to-back: accept every W+2 cycles with in_valid/out_ready held high
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            gold     = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            gold_ovf = (ra[W-1] == rb[W-1]) && (gold[W-1] != ra[W-1]);
            check("b2b.in_ready", 16'(in_ready), 16'd1);
            a = ra; b = rb; cin = rc;
            repeat (W) @(negedge clk);
            check("b2b.early", 16'(out_valid), 16'd0);
            @(negedge clk);
            check("b2b.out_valid", 16'(out_valid), 16'd1);
            check("b2b.sum", 16'(sum), 16'(gold[W-1:0]));
            check("b2b.cout", 16'(cout), 16'(gold[W]));
`ifdef SERIAL_ADD_OVF_EN
            check("b2b.ovf", 16'(ovf), 16'(gold_ovf));
`else
            if (gold_ovf === 1'bx) $display("unexpected x in ovf model");
`endif
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
